// File: rtl/qlearn_pkg.sv
// rtl/qlearn_pkg.sv - shared FSM state type and default widths for the Q-learning update controller
package qlearn_pkg;

    localparam int QL_S_W        = 4;
    localparam int QL_A_W        = 2;
    localparam int QL_DATA_WIDTH = 8;

    typedef enum logic [2:0] {
        IDLE,
        RD_A,
        RD_B,
        CAP,
        CALC,
        WB
    } state_t;

endpackage

// File: rtl/qlearn_update_ctrl.sv
// rtl/qlearn_update_ctrl.sv - sequences one Q-table update per (s, a, s') transition request
//
// Ports:
//   clk, rst_n                        clock, asynchronous active-low reset
//   tr_valid/tr_ready, tr_s/tr_a/tr_sn transition request handshake and fields
//   q_rd_*, r_rd_*, qm_rd_*           Q, R and Qmax table reads (data one cycle after en)
//   upd_start, upd_q/r/qmax           operands handed to the update datapath
//   upd_done, upd_qnew                result returned by the update datapath
//   q_wr_*, qm_wr_*                   Q and Qmax table write-back
//   busy, tr_count, err               status: active, completed updates, sticky watchdog error
module qlearn_update_ctrl
    import qlearn_pkg::*;
#(
    parameter int S_W        = QL_S_W,
    parameter int A_W        = QL_A_W,
    parameter int DATA_WIDTH = QL_DATA_WIDTH,
    parameter int WD_LIMIT   = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  tr_valid,
    output logic                  tr_ready,
    input  logic [S_W-1:0]        tr_s,
    input  logic [A_W-1:0]        tr_a,
    input  logic [S_W-1:0]        tr_sn,
    output logic                  q_rd_en,
    output logic [S_W+A_W-1:0]    q_rd_addr,
    input  logic [DATA_WIDTH-1:0] q_rd_data,
    output logic                  r_rd_en,
    output logic [S_W+A_W-1:0]    r_rd_addr,
    input  logic [DATA_WIDTH-1:0] r_rd_data,
    output logic                  qm_rd_en,
    output logic [S_W-1:0]        qm_rd_addr,
    input  logic [DATA_WIDTH-1:0] qm_rd_data,
    output logic                  upd_start,
    output logic [DATA_WIDTH-1:0] upd_q,
    output logic [DATA_WIDTH-1:0] upd_r,
    output logic [DATA_WIDTH-1:0] upd_qmax,
    input  logic                  upd_done,
    input  logic [DATA_WIDTH-1:0] upd_qnew,
    output logic                  q_wr_en,
    output logic [S_W+A_W-1:0]    q_wr_addr,
    output logic [DATA_WIDTH-1:0] q_wr_data,
    output logic                  qm_wr_en,
    output logic [S_W-1:0]        qm_wr_addr,
    output logic [DATA_WIDTH-1:0] qm_wr_data,
    output logic                  busy,
    output logic [15:0]           tr_count,
    output logic                  err
);

    localparam int              WD_W    = $clog2(WD_LIMIT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(WD_LIMIT - 1);

    state_t                  state;
    state_t                  state_next;
    logic [S_W-1:0]          s_q;
    logic [A_W-1:0]          a_q;
    logic [DATA_WIDTH-1:0]   qmax_s_q;
    logic                    qm_upd_q;
    logic [WD_W-1:0]         wd_cnt;
    logic                    wd_abort;

    // wd_cnt is zero on CALC entry, so the last permitted CALC cycle is
    // the WD_LIMIT-th one; abort only if done is still absent there.
    assign wd_abort = (state == CALC) && !upd_done && (wd_cnt == WD_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        tr_ready   = 1'b0;
        q_rd_en    = 1'b0;
        r_rd_en    = 1'b0;
        qm_rd_en   = 1'b0;
        upd_start  = 1'b0;
        q_wr_en    = 1'b0;
        qm_wr_en   = 1'b0;
        case (state)
            IDLE: begin
                tr_ready = 1'b1;
                if (tr_valid) begin
                    state_next = RD_A;
                end
            end
            RD_A: begin
                q_rd_en    = 1'b1;
                r_rd_en    = 1'b1;
                qm_rd_en   = 1'b1;
                state_next = RD_B;
            end
            RD_B: begin
                qm_rd_en   = 1'b1;
                state_next = CAP;
            end
            CAP: begin
                upd_start  = 1'b1;
                state_next = CALC;
            end
            CALC: begin
                if (upd_done) begin
                    state_next = WB;
                end else if (wd_abort) begin
                    state_next = IDLE;
                end
            end
            WB: begin
                q_wr_en    = 1'b1;
                qm_wr_en   = qm_upd_q;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        busy = !tr_ready;
    end

    // Address/data registers only change on the edge that starts their
    // enable pulse, so they hold their last value between transactions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q        <= '0;
            a_q        <= '0;
            q_rd_addr  <= '0;
            r_rd_addr  <= '0;
            qm_rd_addr <= '0;
            upd_q      <= '0;
            upd_r      <= '0;
            upd_qmax   <= '0;
            qmax_s_q   <= '0;
            qm_upd_q   <= 1'b0;
            q_wr_addr  <= '0;
            q_wr_data  <= '0;
            qm_wr_addr <= '0;
            qm_wr_data <= '0;
            wd_cnt     <= '0;
            err        <= 1'b0;
            tr_count   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (tr_valid) begin
                        s_q        <= tr_s;
                        a_q        <= tr_a;
                        q_rd_addr  <= {tr_s, tr_a};
                        r_rd_addr  <= {tr_s, tr_a};
                        qm_rd_addr <= tr_sn;
                    end
                end
                RD_A: begin
                    qm_rd_addr <= s_q;
                end
                RD_B: begin
                    upd_q    <= q_rd_data;
                    upd_r    <= r_rd_data;
                    upd_qmax <= qm_rd_data;
                end
                CAP: begin
                    qmax_s_q <= qm_rd_data;
                end
                CALC: begin
                    if (upd_done) begin
                        q_wr_addr <= {s_q, a_q};
                        q_wr_data <= upd_qnew;
                        qm_upd_q  <= (upd_qnew > qmax_s_q);
                        if (upd_qnew > qmax_s_q) begin
                            qm_wr_addr <= s_q;
                            qm_wr_data <= upd_qnew;
                        end
                    end
                end
                WB: begin
                    tr_count <= tr_count + 16'd1;
                end
                default: ;
            endcase

            if (state == CALC) begin
                wd_cnt <= wd_cnt + 1'b1;
            end else begin
                wd_cnt <= '0;
            end

            if (wd_abort) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_qlearn_update_ctrl.sv
// tb/tb_qlearn_update_ctrl.sv - scoreboard bench for qlearn_update_ctrl
module tb_qlearn_update_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        tr_valid;
    logic        tr_ready;
    logic [3:0]  tr_s;
    logic [1:0]  tr_a;
    logic [3:0]  tr_sn;
    logic        q_rd_en;
    logic [5:0]  q_rd_addr;
    logic [7:0]  q_rd_data;
    logic        r_rd_en;
    logic [5:0]  r_rd_addr;
    logic [7:0]  r_rd_data;
    logic        qm_rd_en;
    logic [3:0]  qm_rd_addr;
    logic [7:0]  qm_rd_data;
    logic        upd_start;
    logic [7:0]  upd_q;
    logic [7:0]  upd_r;
    logic [7:0]  upd_qmax;
    logic        upd_done;
    logic [7:0]  upd_qnew;
    logic        q_wr_en;
    logic [5:0]  q_wr_addr;
    logic [7:0]  q_wr_data;
    logic        qm_wr_en;
    logic [3:0]  qm_wr_addr;
    logic [7:0]  qm_wr_data;
    logic        busy;
    logic [15:0] tr_count;
    logic        err;

    qlearn_update_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .tr_valid(tr_valid), .tr_ready(tr_ready), .tr_s(tr_s), .tr_a(tr_a), .tr_sn(tr_sn),
        .q_rd_en(q_rd_en), .q_rd_addr(q_rd_addr), .q_rd_data(q_rd_data),
        .r_rd_en(r_rd_en), .r_rd_addr(r_rd_addr), .r_rd_data(r_rd_data),
        .qm_rd_en(qm_rd_en), .qm_rd_addr(qm_rd_addr), .qm_rd_data(qm_rd_data),
        .upd_start(upd_start), .upd_q(upd_q), .upd_r(upd_r), .upd_qmax(upd_qmax),
        .upd_done(upd_done), .upd_qnew(upd_qnew),
        .q_wr_en(q_wr_en), .q_wr_addr(q_wr_addr), .q_wr_data(q_wr_data),
        .qm_wr_en(qm_wr_en), .qm_wr_addr(qm_wr_addr), .qm_wr_data(qm_wr_data),
        .busy(busy), .tr_count(tr_count), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0] addr;
        logic       wr;
        logic [7:0] qd;
        logic       qm_en;
        logic [3:0] qm_addr;
        logic [7:0] uq;
        logic [7:0] ur;
        logic [7:0] uqm;
    } exp_t;

    exp_t       exp_q[$];
    logic [3:0] qm_q[$];
    logic [7:0] q_mem  [64];
    logic [7:0] r_mem  [64];
    logic [7:0] qm_mem [16];

    int   errors = 0;
    int   checks = 0;
    int   txn_cnt = 0;
    int   resp_dly = 0;
    bit   resp_hang = 1'b0;
    bit   resp_stray = 1'b0;
    logic [7:0] resp_qnew = 8'h00;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Table models: one-cycle read latency
    always @(posedge clk) begin
        if (q_rd_en)  q_rd_data  <= q_mem[q_rd_addr];
        if (r_rd_en)  r_rd_data  <= r_mem[r_rd_addr];
        if (qm_rd_en) qm_rd_data <= qm_mem[qm_rd_addr];
    end

    // Update datapath model; optional stray done during the upd_start cycle
    initial begin
        upd_done = 1'b0;
        upd_qnew = 8'h00;
        forever begin
            @(negedge clk);
            if (upd_start && !resp_hang) begin
                if (resp_stray) begin
                    upd_done = 1'b1;
                    upd_qnew = 8'hEE;
                end
                @(negedge clk);
                upd_done = 1'b0;
                repeat (resp_dly) @(negedge clk);
                upd_done = 1'b1;
                upd_qnew = resp_qnew;
                @(negedge clk);
                upd_done = 1'b0;
            end
        end
    end

    // Scoreboard monitor
    always @(negedge clk) begin
        if (q_rd_en || r_rd_en || upd_start || q_wr_en || qm_wr_en) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_activity", 32'd1, 32'd0);
            end else begin
                if (q_rd_en) chk("q_rd_addr", q_rd_addr, exp_q[0].addr);
                if (r_rd_en) chk("r_rd_addr", r_rd_addr, exp_q[0].addr);
                if (upd_start) begin
                    chk("upd_q", upd_q, exp_q[0].uq);
                    chk("upd_r", upd_r, exp_q[0].ur);
                    chk("upd_qmax", upd_qmax, exp_q[0].uqm);
                end
                if (q_wr_en) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("wr_allowed", 32'd1, {31'd0, e.wr});
                    chk("q_wr_addr", q_wr_addr, e.addr);
                    chk("q_wr_data", q_wr_data, e.qd);
                    chk("qm_wr_en", qm_wr_en, e.qm_en);
                    if (qm_wr_en) begin
                        chk("qm_wr_addr", qm_wr_addr, e.qm_addr);
                        chk("qm_wr_data", qm_wr_data, e.qd);
                    end
                end else if (qm_wr_en) begin
                    chk("qm_wr_without_q_wr", 32'd1, 32'd0);
                end
            end
        end
        if (qm_rd_en) begin
            if (qm_q.size() == 0) chk("qm_rd_unexpected", 32'd1, 32'd0);
            else                  chk("qm_rd_addr", qm_rd_addr, qm_q.pop_front());
        end
    end

    task automatic drive_req(input logic [3:0] s, input logic [1:0] a, input logic [3:0] sn,
                             input logic [7:0] qnew, input bit wr);
        exp_t e;
        int   n;
        n = 0;
        while (!tr_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("accept_wait", tr_ready, 1);
        e.addr    = {s, a};
        e.wr      = wr;
        e.qd      = qnew;
        e.qm_en   = (qnew > qm_mem[s]);
        e.qm_addr = s;
        e.uq      = q_mem[{s, a}];
        e.ur      = r_mem[{s, a}];
        e.uqm     = qm_mem[sn];
        exp_q.push_back(e);
        qm_q.push_back(sn);
        qm_q.push_back(s);
        tr_s     = s;
        tr_a     = a;
        tr_sn    = sn;
        tr_valid = 1'b1;
        @(negedge clk);
        tr_valid = 1'b0;
    endtask

    task automatic run_txn(input logic [3:0] s, input logic [1:0] a, input logic [3:0] sn,
                           input logic [7:0] qnew, input int dly, input bit hang, input bit stray);
        int n;
        resp_qnew  = qnew;
        resp_dly   = dly;
        resp_hang  = hang;
        resp_stray = stray;
        drive_req(s, a, sn, qnew, !hang);
        n = 0;
        while (!tr_ready && n < 400) begin
            n++;
            @(negedge clk);
        end
        chk("busy_cycles", n, hang ? 258 : 5 + dly);
        if (hang) begin
            exp_q.delete();
        end else begin
            txn_cnt++;
            chk("write_issued", exp_q.size(), 0);
        end
        chk("tr_count", tr_count, 16'(txn_cnt));
        chk("busy_vs_ready", busy, !tr_ready);
    endtask

    initial begin
        rst_n    = 1'b0;
        tr_valid = 1'b0;
        tr_s     = '0;
        tr_a     = '0;
        tr_sn    = '0;
        for (int i = 0; i < 64; i++) begin
            q_mem[i] = 8'($urandom);
            r_mem[i] = 8'($urandom);
        end
        for (int i = 0; i < 16; i++) qm_mem[i] = 8'($urandom);
        q_mem[13] = 8'd10;
        r_mem[13] = 8'd4;
        qm_mem[5] = 8'd20;
        qm_mem[3] = 8'd12;
        qm_mem[7] = 8'd33;

        repeat (3) @(negedge clk);
        chk("rst_tr_ready", tr_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_tr_count", tr_count, 0);
        chk("rst_err", err, 0);
        chk("rst_q_wr_data", q_wr_data, 0);
        chk("rst_qm_rd_addr", qm_rd_addr, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // qnew above Qmax(s): both writes
        run_txn(4'd3, 2'd1, 4'd5, 8'd15, 0, 1'b0, 1'b0);
        // qnew equal to Qmax(s): no Qmax write
        run_txn(4'd3, 2'd1, 4'd5, 8'd12, 0, 1'b0, 1'b0);
        // stray done before CALC plus delayed real done
        run_txn(4'd3, 2'd1, 4'd5, 8'd11, 3, 1'b0, 1'b1);
        // s == s'
        run_txn(4'd7, 2'd2, 4'd7, 8'd40, 1, 1'b0, 1'b0);

        // watchdog abort
        run_txn(4'd2, 2'd0, 4'd9, 8'd0, 0, 1'b1, 1'b0);
        chk("wd_err", err, 1);
        chk("wd_tr_ready", tr_ready, 1);
        run_txn(4'd1, 2'd3, 4'd4, 8'd99, 2, 1'b0, 1'b0);
        chk("err_sticky", err, 1);

        // reset while in CALC
        resp_hang = 1'b1;
        drive_req(4'd6, 2'd1, 4'd8, 8'd0, 1'b0);
        repeat (4) @(negedge clk);
        chk("in_calc_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_tr_ready", tr_ready, 1);
        chk("arst_err", err, 0);
        chk("arst_tr_count", tr_count, 0);
        chk("arst_q_wr_en", q_wr_en, 0);
        chk("arst_upd_q", upd_q, 0);
        chk("arst_q_rd_addr", q_rd_addr, 0);
        exp_q.delete();
        qm_q.delete();
        txn_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_txn(4'd3, 2'd1, 4'd5, 8'd15, 0, 1'b0, 1'b0);

        // back-to-back random traffic
        for (int i = 0; i < 20; i++) begin
            run_txn(4'($urandom), 2'($urandom), 4'($urandom), 8'($urandom),
                    int'($urandom_range(0, 4)), 1'b0, (i % 3) == 0);
        end

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/qlearn_update_ctrl.md
QLEARN_UPDATE_CTRL -- requirements
Module: qlearn_update_ctrl

Interface
REQ-001 Parameter S_W, default 4: state index width.
REQ-002 Parameter A_W, default 2: action index width; Q address = {s,a}, width S_W+A_W.
REQ-003 Parameter DATA_WIDTH, default 8: unsigned table entry width.
REQ-004 Parameter WD_LIMIT, default 255: max cycles waiting for upd_done.
REQ-005 Port clk, input, 1: single clock, rising edge.
REQ-006 Port rst_n, input, 1: reset, asynchronous, active-low.
REQ-007 Ports tr_valid in 1, tr_ready out 1, tr_s in S_W, tr_a in A_W, tr_sn in S_W: transition request (s, a, s').
REQ-008 Ports q_rd_en out 1, q_rd_addr out S_W+A_W, q_rd_data in DATA_WIDTH: Q-table read.
REQ-009 Ports r_rd_en out 1, r_rd_addr out S_W+A_W, r_rd_data in DATA_WIDTH: R-table read.
REQ-010 Ports qm_rd_en out 1, qm_rd_addr out S_W, qm_rd_data in DATA_WIDTH: Qmax-table read.
REQ-011 Ports upd_start out 1, upd_q/upd_r/upd_qmax out DATA_WIDTH each, upd_done in 1, upd_qnew in DATA_WIDTH: update datapath.
REQ-012 Ports q_wr_en out 1, q_wr_addr out S_W+A_W, q_wr_data out DATA_WIDTH; qm_wr_en out 1, qm_wr_addr out S_W, qm_wr_data out DATA_WIDTH: write-back.
REQ-013 Ports busy out 1, tr_count out 16, err out 1: status.

Function
REQ-014 All table reads SHALL return data exactly one cycle after rd_en; controller captures it then.
REQ-015 FSM states SHALL be IDLE, RD_A, RD_B, CAP, CALC, WB.
REQ-016 IDLE: tr_ready=1; on tr_valid, latch s, a, s' -> RD_A.
REQ-017 RD_A: one-cycle pulse q_rd_en, r_rd_en ({s,a}), qm_rd_en (s') -> RD_B.
REQ-018 RD_B: capture Q, R, Qmax(s'); pulse qm_rd_en at s -> CAP.
REQ-019 CAP: capture Qmax(s); pulse upd_start with captured Q, R, Qmax(s') on upd_* -> CALC.
REQ-020 CALC: sample upd_done from the cycle after upd_start; on upd_done capture upd_qnew -> WB.
REQ-021 CALC watchdog: after WD_LIMIT cycles without upd_done, set err (sticky), no writes, -> IDLE.
REQ-022 WB: one-cycle q_wr_en, q_wr_data = qnew; qm_wr_en same cycle only if qnew > Qmax(s) (unsigned, strict) -> IDLE.
REQ-023 tr_count SHALL increment by 1 per WB, wrapping 0xFFFF -> 0; aborts do not count.
REQ-024 busy = (state != IDLE); tr_ready = (state == IDLE).
REQ-025 s == s' SHALL be handled normally: both Qmax reads target the same address.
REQ-026 upd_done outside CALC SHALL be ignored.
REQ-027 All enables SHALL be single-cycle pulses; address/data outputs hold last value when enables low.

Reset
REQ-028 rst_n low SHALL immediately force IDLE, all enables/upd_start 0, addresses/data 0, tr_count 0, err 0, busy 0, tr_ready 1.
REQ-029 Reset mid-transaction SHALL abort it with no write issued; after release, the next tr_valid starts cleanly.

Structure
REQ-030 Package qlearn_pkg SHALL hold the FSM state enum and default widths S_W, A_W, DATA_WIDTH.
REQ-031 Single module; watchdog counter is inline, no sub-module.

Verification
REQ-032 s=3,a=1,s'=5; Q=10,R=4,Qmax[5]=20,Qmax[3]=12; upd_qnew=15 -> q_wr addr 13 data 15, qm_wr addr 3 data 15, tr_count=1.
REQ-033 Same as REQ-032 with upd_qnew=12 -> q_wr data 12, no qm_wr (equal value not written).
REQ-034 upd_done held low 255 cycles -> err=1, no q_wr/qm_wr, return to IDLE, tr_ready=1.
REQ-035 rst_n low during CALC -> all outputs at reset values, no write; next request completes normally.
REQ-036 s=s'=7 -> qm_rd_addr=7 on both reads; upd_qmax equals Qmax[7].
REQ-037 65536 back-to-back transactions -> tr_count wraps to 0; tr_ready low for the whole of each transaction.
